// File: rtl/down_count_timer_pkg.sv
// down_count_timer_pkg
//   Shared declarations for the down-count timer: FSM state encoding and
//   the default counter width. Imported by the interface, the core and the top.
package down_count_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dct_state_e;

endpackage

// File: rtl/down_count_timer_if.sv
// down_count_timer_if
//   Bundles the control and status signals of the down-count timer.
//   Signals:
//     load     strobe; load_val is sampled on the same rising edge
//     load_val start value of the countdown
//     en       count enable, one decrement per enabled cycle in RUN
//     out      registered count value
//     zero     out == 0
//     tc       one-cycle terminal-count pulse
//     busy     FSM in RUN
//     done     FSM in DONE (sticky until load or reset)
//     state    FSM state, exposed for observation
//   Modports: master (controller side), slave (timer side).
//   Strobe semantics: there is no back-pressure. load and en are sampled on
//   every rising edge; a load is accepted unconditionally in the cycle it is
//   high, and its effect is visible on out after that edge.
interface down_count_timer_if
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             busy;
  logic             done;
  dct_state_e       state;

  modport master (
    output load, load_val, en,
    input  out, zero, tc, busy, done, state
  );

  modport slave (
    input  load, load_val, en,
    output out, zero, tc, busy, done, state
  );

endinterface

// File: rtl/down_count_timer_core.sv
// down_count_core
//   WIDTH-bit count register with load / decrement / hold control and a
//   zero decode taken directly from the register.
//   Ports:
//     clk_i       rising-edge clock
//     reset_i     synchronous active-high reset (count -> 0)
//     load_i      load load_val_i (has priority over dec_i)
//     load_val_i  value to load
//     dec_i       decrement by one; ignored at zero so the count never wraps
//     cnt_o       registered count
//     zero_o      cnt_o == 0
module down_count_core
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/down_count_timer.sv
// down_count_timer
//   Loadable down-counter / timer. A load starts a countdown from load_val;
//   each enabled cycle in RUN decrements by one. Reaching zero raises a
//   one-cycle tc pulse and parks the FSM in DONE.
//   Optional feature macro: AUTO_RELOAD_EN. When defined, the terminal step
//   reloads the last loaded value and stays in RUN (periodic tc, DONE unused).
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    down_count_timer_if.slave (load, load_val, en, out, zero, tc,
//            busy, done, state)
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  down_count_timer_if.slave        bus
);

  dct_state_e       state_q, state_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  logic             core_load;
  logic [WIDTH-1:0] core_val;
  logic             core_dec;
  logic [WIDTH-1:0] cnt;
  logic             cnt_zero;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (core_load),
    .load_val_i (core_val),
    .dec_i      (core_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // Core load source: an external load takes load_val; otherwise the only
  // other load is the auto-reload of reload_q on the terminal step.
  always_comb begin
    state_d   = state_q;
    tc_d      = 1'b0;
    reload_d  = reload_q;
    core_load = bus.load;
    core_val  = bus.load ? bus.load_val : reload_q;
    core_dec  = 1'b0;

    if (bus.load) begin
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && bus.en) begin
      if (cnt == WIDTH'(1)) begin
        // Terminal step
        tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        core_load = 1'b1;
`else
        core_dec = 1'b1;
        state_d  = DONE;
`endif
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tc_q     <= 1'b0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      reload_q <= reload_d;
    end
  end

  assign bus.out   = cnt;
  assign bus.zero  = cnt_zero;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Synchronous, loadable down-counter/timer. It is the counterpart of the team's free-running synchronous up-counter: software or a controller loads a start value, and the block counts toward zero. It raises a one-cycle terminal-count pulse when the count reaches zero and reports busy/done status. It serves as the interval and timeout generator alongside the up-counter in the same clock domain.

## Interface
- WIDTH, 4, counter width in bits (legal 2..16)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  load strobe; samples load_val on the same edge
- load_val  input  WIDTH  start value for the countdown
- en  input  1  count enable; decrements one per enabled cycle while running
- out  output  WIDTH  current count value (registered)
- zero  output  1  high whenever out == 0 (decoded from the out register, no extra latency)
- tc  output  1  terminal-count pulse, exactly one cycle wide (registered)
- busy  output  1  high in state RUN
- done  output  1  high in state DONE; sticky until the next load or reset

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, out=0, zero=1, tc=0, busy=0, done=0, internal reload register=0.
- Priority on each edge is reset > load > en.
- load=1 in any state:
  - out<=load_val and reload register<=load_val; tc<=0.
  - If load_val != 0, go to RUN.
  - If load_val == 0, go to IDLE. No tc is generated.
- RUN with en=1 and out>1: out<=out-1.
- RUN with en=0: out holds; busy stays 1 (pause).
- RUN with en=1 and out==1 (terminal step):
  - out<=0, tc<=1, go to DONE.
  - With AUTO_RELOAD_EN defined, this behaviour is replaced as described under Configuration.
- IDLE and DONE ignore en. out holds and never underflows.
- tc deasserts on the cycle after it is set, unless another terminal step occurs in that cycle.
- Arithmetic is unsigned and modulo-free: decrement is applied only when out>1 or on the terminal step. There is no wrap from 0 to 2^WIDTH-1.
- Reset asserted mid-count forces the reset values on that edge, regardless of load or en.

## Timing
- The load sampled at edge N is visible on out after edge N.
- From load value L with en held high from edge N+1 onward: out reaches 0 and tc=1 after edge N+L, which is L enabled cycles.
- Each en-low cycle in RUN delays the terminal count by exactly one cycle.
- Load latency is 1 cycle. zero tracks out combinationally from the register.
- Load and terminal step in the same cycle: the load wins, tc stays 0, and the count restarts from load_val.

## Configuration
- AUTO_RELOAD_EN defined:
  - On the terminal step, out<=reload register, tc<=1, and the state stays RUN. The counter runs periodically with period L enabled cycles.
  - DONE is unreachable; done stays 0.
  - A reload value of 1 gives tc on every enabled cycle.
- AUTO_RELOAD_EN undefined:
  - One-shot behaviour as in Operation: stop in DONE with out=0.

## Structure
- Shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the default WIDTH constant
- One sub-module, down_count_core: the WIDTH-bit register with load/decrement/hold control and the zero decode.
- The top level holds the FSM, the reload register, tc/busy/done generation, and the AUTO_RELOAD_EN logic.

## Test plan
- Reset for 2 cycles, then release -> out=0, zero=1, tc=0, busy=0, done=0.
- load_val=5 with load for 1 cycle, en held high -> out 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle out first reads 0; then done=1, busy=0.
- load_val=3, en toggling 1,0,1,0,1 -> out 3,2,2,1,1,0; tc fires 5 cycles after the load.
- Load 9, then load 4 when out=6 -> out=4 on the next cycle and the countdown restarts; a load of 0 -> state IDLE, no tc, done=0.
- Reset asserted when out=2 in RUN -> next cycle all reset values; en ignored afterward until a load.
- AUTO_RELOAD_EN, load_val=3, en high -> out 3,2,1,3,2,1,...; tc high every 3rd cycle; done stays 0; WIDTH=4 with load_val=15 -> tc after 15 cycles.
